// File: rtl/contador_eventos.sv
// Bank of per-channel event counters with shadow snapshot and readout mux.
// Channel 0 counts non-NOP instructions; channels 1..N-1 count external strobes.
module contador_eventos #(
    parameter int NUM_CHANNELS       = 4,
    parameter int CONTADOR_LENGTH    = 32,
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int SATURATE           = 0
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable,
    input  logic [INSTRUCTION_LENGTH-1:0] i_instruction,
    input  logic [NUM_CHANNELS-2:0]       i_events,
    input  logic [NUM_CHANNELS-1:0]       i_clear,
    input  logic                          i_snapshot,
    input  logic [3:0]                    i_sel,
    output logic [CONTADOR_LENGTH-1:0]    o_cuenta,
    output logic [NUM_CHANNELS-1:0]       o_overflow,
    output logic                          o_snapshot_valid
);

    localparam logic [CONTADOR_LENGTH-1:0] MAXIMO = '1;

    logic [NUM_CHANNELS-1:0]    evento;
    logic [CONTADOR_LENGTH-1:0] cuenta [NUM_CHANNELS];
    logic [CONTADOR_LENGTH-1:0] sombra [NUM_CHANNELS];

    assign evento = {NUM_CHANNELS{i_enable}} & {i_events, (i_instruction != '0)};

    // Shadows take the pre-edge live value, so same-cycle increments/clears are excluded.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cuenta[c] <= '0;
                sombra[c] <= '0;
            end
            o_overflow       <= '0;
            o_snapshot_valid <= 1'b0;
        end else begin
            if (i_snapshot) begin
                for (int c = 0; c < NUM_CHANNELS; c++)
                    sombra[c] <= cuenta[c];
                o_snapshot_valid <= 1'b1;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (i_clear[c]) begin
                    cuenta[c]     <= '0;
                    o_overflow[c] <= 1'b0;
                end else if (evento[c]) begin
                    if (cuenta[c] == MAXIMO) begin
                        o_overflow[c] <= 1'b1;
                        if (SATURATE == 0)
                            cuenta[c] <= '0;
                    end else begin
                        cuenta[c] <= cuenta[c] + CONTADOR_LENGTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        o_cuenta = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            if (i_sel == 4'(c))
                o_cuenta = sombra[c];
    end

endmodule

// File: tb/tb_contador_eventos.sv
// Scoreboard bench: one wrap and one saturate instance share stimulus; a
// queue-based monitor compares each cycle against an arithmetic reference model.
module tb_contador_eventos;

    localparam int NC  = 4;
    localparam int CL  = 4;
    localparam int IL  = 32;
    localparam int MAX = (1 << CL) - 1;

    logic          clk;
    logic          rst, en, snap;
    logic [IL-1:0] instr;
    logic [NC-2:0] ev;
    logic [NC-1:0] clr;
    logic [3:0]    sel;
    logic [CL-1:0] cuenta_w, cuenta_s;
    logic [NC-1:0] ovf_w, ovf_s;
    logic          sv_w, sv_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    contador_eventos #(.NUM_CHANNELS(NC), .CONTADOR_LENGTH(CL), .INSTRUCTION_LENGTH(IL), .SATURATE(0)) u_wrap (
        .i_clock(clk), .i_soft_reset(rst), .i_enable(en), .i_instruction(instr), .i_events(ev),
        .i_clear(clr), .i_snapshot(snap), .i_sel(sel),
        .o_cuenta(cuenta_w), .o_overflow(ovf_w), .o_snapshot_valid(sv_w));

    contador_eventos #(.NUM_CHANNELS(NC), .CONTADOR_LENGTH(CL), .INSTRUCTION_LENGTH(IL), .SATURATE(1)) u_sat (
        .i_clock(clk), .i_soft_reset(rst), .i_enable(en), .i_instruction(instr), .i_events(ev),
        .i_clear(clr), .i_snapshot(snap), .i_sel(sel),
        .o_cuenta(cuenta_s), .o_overflow(ovf_s), .o_snapshot_valid(sv_s));

    typedef struct {
        int      cw, cs;
        bit [NC-1:0] ow, os;
        bit      vw, vs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: index 0 = wrap instance, 1 = saturate instance
    int      live [2][NC];
    int      shad [2][NC];
    bit [NC-1:0] ovf [2];
    bit      snap_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [IL-1:0] ins,
                        input logic [NC-2:0] evs, input logic [NC-1:0] cl,
                        input bit sn, input logic [3:0] s);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; instr = ins; ev = evs; clr = cl; snap = sn; sel = s;
        if (r) begin
            for (int m = 0; m < 2; m++) begin
                ovf[m] = '0;
                for (int c = 0; c < NC; c++) begin live[m][c] = 0; shad[m][c] = 0; end
            end
            snap_seen = 0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (sn)
                    for (int c = 0; c < NC; c++) shad[m][c] = live[m][c];
                for (int c = 0; c < NC; c++) begin
                    bit hit;
                    int nxt;
                    hit = e && ((c == 0) ? (ins != 0) : (evs[c-1] == 1'b1));
                    if (cl[c]) begin
                        live[m][c] = 0;
                        ovf[m][c]  = 0;
                    end else if (hit) begin
                        nxt = live[m][c] + 1;
                        if (nxt > MAX) ovf[m][c] = 1;
                        live[m][c] = (m == 0) ? (nxt % (MAX + 1)) : ((nxt > MAX) ? MAX : nxt);
                    end
                end
            end
            if (sn) snap_seen = 1;
        end
        x.cw = (s < NC) ? shad[0][s] : 0;
        x.cs = (s < NC) ? shad[1][s] : 0;
        x.ow = ovf[0];
        x.os = ovf[1];
        x.vw = snap_seen;
        x.vs = snap_seen;
        q.push_back(x);
    endtask

    task automatic idle(input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, s);
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("cuenta_wrap", 32'(cuenta_w), 32'(x.cw));
            chk("cuenta_sat",  32'(cuenta_s), 32'(x.cs));
            chk("overflow_wrap", 32'(ovf_w), 32'(x.ow));
            chk("overflow_sat",  32'(ovf_s), 32'(x.os));
            chk("snapvalid_wrap", 32'(sv_w), 32'(x.vw));
            chk("snapvalid_sat",  32'(sv_s), 32'(x.vs));
        end
    end

    initial begin
        rst = 1; en = 0; instr = '0; ev = '0; clr = '0; snap = 0; sel = '0;
        step(1, 0, '0, '0, '0, 0, 0);
        step(1, 1, 32'h1, '1, '0, 1, 0);
        for (int s = 0; s < 16; s++) step(0, 0, '0, '0, '0, 0, 4'(s));

        // Count/readout: 7 instructions, 3 channel-1 strobes
        for (int i = 0; i < 10; i++)
            step(0, 1, (i < 7) ? 32'h1 : 32'h0, (i >= 7) ? 3'b001 : 3'b000, '0, 0, 0);
        step(0, 0, '0, '0, '0, 1, 0);
        for (int s = 0; s <= NC; s++) step(0, 0, '0, '0, '0, 0, 4'(s));

        // Wrap / overflow on channel 1
        step(0, 0, '0, '0, '1, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 1, '0, 3'b001, '0, 0, 1);
        step(0, 0, '0, '0, '0, 1, 1);
        step(0, 1, '0, 3'b001, '0, 0, 1);
        step(0, 0, '0, '0, '0, 1, 1);
        idle(1, 1);

        // Saturation on channel 2
        step(0, 0, '0, '0, '1, 0, 2);
        for (int i = 0; i < 20; i++) step(0, 1, '0, 3'b010, '0, 0, 2);
        step(0, 0, '0, '0, '0, 1, 2);
        idle(2, 2);

        // Clear beats event, snapshot sees pre-clear value
        step(0, 0, '0, '0, '1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, '0, 3'b001, '0, 0, 1);
        step(0, 1, '0, 3'b001, 4'b0010, 1, 1);
        step(0, 1, '0, 3'b001, '0, 0, 1);
        step(0, 0, '0, '0, '0, 1, 1);
        idle(1, 1);

        // Reset mid-operation with everything asserted
        for (int i = 0; i < 18; i++) step(0, 1, 32'hdead, '1, '0, 0, 0);
        step(0, 0, '0, '0, '0, 1, 3);
        step(1, 1, 32'hbeef, '1, '1, 1, 3);
        for (int s = 0; s < NC; s++) step(0, 0, '0, '0, '0, 0, 4'(s));

        // Gating: enable low freezes counting, snapshot still works
        for (int i = 0; i < 3; i++) step(0, 1, 32'h10, '1, '0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h10, '1, '0, 0, 0);
        step(0, 0, 32'h10, '1, '0, 1, 0);
        for (int s = 0; s <= NC; s++) step(0, 0, '0, '0, '0, 0, 4'(s));
        step(0, 0, '0, '0, '0, 0, 4'(NC));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [NC-1:0] cl;
            for (int c = 0; c < NC; c++) cl[c] = ($urandom_range(0, 11) == 0);
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                 (NC-1)'($urandom), cl, ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)));
        end

        // Drain, bounded
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
